// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//
// Run-control and debug-navigation front end for the single-cycle CPU.
// Everything runs on clk: the CPU is advanced by a one-cycle clock enable
// (cpu_ce) rather than a divided clock.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | after reset; waits for go, CPU frozen
//   RUN   | free run, cpu_ce follows the divider tick
//   STEP  | single step, cpu_ce follows each accepted step press
//   HALTED| CPU reported halt; go resumes with a resume+enable cycle
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   speed_sel[1:0]  divisor select (0 slowest .. 3 fastest)
//   run_mode        1 free run, 0 single step (level)
//   go_btn          raw start/resume button
//   step_btn        raw single-step button
//   inc_btn         raw mem_addr increment button
//   dec_btn         raw mem_addr decrement button
//   addr_clr        level, forces mem_addr to 0
//   cpu_halt        halt flag from the CPU
//   cpu_ce          one-cycle CPU clock enable (combinational)
//   cpu_resume      one-cycle resume pulse, coincident with cpu_ce
//   mem_addr        debug view address (wraps)
//   state[1:0]      00 IDLE, 01 RUN, 10 STEP, 11 HALTED
//   cycle_count     saturating count of cpu_ce pulses
module cpu_run_ctrl #(
   parameter int unsigned DIV_W      = 32,
   parameter int unsigned DIV0       = 2500000,
   parameter int unsigned DIV1       = 250000,
   parameter int unsigned DIV2       = 25000,
   parameter int unsigned DIV3       = 2,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned DEB_CYCLES = 250000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        speed_sel,
   input  logic              run_mode,
   input  logic              go_btn,
   input  logic              step_btn,
   input  logic              inc_btn,
   input  logic              dec_btn,
   input  logic              addr_clr,
   input  logic              cpu_halt,
   output logic              cpu_ce,
   output logic              cpu_resume,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   localparam int BTN_GO   = 0;
   localparam int BTN_STEP = 1;
   localparam int BTN_INC  = 2;
   localparam int BTN_DEC  = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_HALT = 2'b11
   } state_t;

   // ---------------------------------------------------------------------
   // Button conditioning: 2-flop sync, stability counter, rising-edge pulse
   // ---------------------------------------------------------------------
   logic [3:0]       btn_raw;
   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [3:0]       acc_q, acc_d;
   logic [3:0]       acc_dly_q, acc_dly_d;
   logic [3:0]       pulse_q, pulse_d;
   logic [DEB_W-1:0] deb_cnt_q [4];
   logic [DEB_W-1:0] deb_cnt_d [4];

   assign btn_raw = {dec_btn, inc_btn, step_btn, go_btn};

   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      acc_d     = acc_q;
      acc_dly_d = acc_q;
      // Edge detect on the accepted level against its one-cycle delay; the
      // pulse is registered so cpu_ce is driven only from flops.
      pulse_d   = acc_q & ~acc_dly_q;
      for (int i = 0; i < 4; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != acc_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               acc_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         acc_q     <= '0;
         acc_dly_q <= '0;
         pulse_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         acc_q     <= acc_d;
         acc_dly_q <= acc_dly_d;
         pulse_q   <= pulse_d;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
      end
   end

   logic go_p, step_p, inc_p, dec_p;
   assign go_p   = pulse_q[BTN_GO];
   assign step_p = pulse_q[BTN_STEP];
   assign inc_p  = pulse_q[BTN_INC];
   assign dec_p  = pulse_q[BTN_DEC];

   // ---------------------------------------------------------------------
   // Divider
   // ---------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] sel_div;
   logic             tick;

   always_comb begin
      sel_div = DIV_W'(DIV0);
      case (speed_sel)
         2'd0:    sel_div = DIV_W'(DIV0);
         2'd1:    sel_div = DIV_W'(DIV1);
         2'd2:    sel_div = DIV_W'(DIV2);
         default: sel_div = DIV_W'(DIV3);
      endcase
   end

   assign tick = (div_cnt_q == (div_q - DIV_W'(1)));

   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      div_d     = div_q;
      // Reloading the divisor only at the period boundary keeps every
      // period a whole period of either the old or the new divisor.
      if (tick) begin
         div_cnt_d = '0;
         div_d     = sel_div;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         div_q     <= DIV_W'(DIV0);
      end else begin
         div_cnt_q <= div_cnt_d;
         div_q     <= div_d;
      end
   end

   // ---------------------------------------------------------------------
   // Run/step/halt state machine
   // ---------------------------------------------------------------------
   state_t state_q, state_d;
   logic   blank_q, blank_d;
   logic   cnt_clr;
   logic   halt_seen;

   // The CPU still reports halt in the cycle right after a resume.
   assign halt_seen = cpu_halt & ~blank_q;

   always_comb begin
      state_d    = state_q;
      blank_d    = 1'b0;
      cpu_ce     = 1'b0;
      cpu_resume = 1'b0;
      cnt_clr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go_p) begin
               state_d = run_mode ? S_RUN : S_STEP;
               cnt_clr = 1'b1;
            end
         end
         S_RUN: begin
            cpu_ce = tick;
            if (halt_seen) begin
               state_d = S_HALT;
            end else if (!run_mode) begin
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            cpu_ce = step_p;
            if (halt_seen) begin
               state_d = S_HALT;
            end else if (run_mode) begin
               state_d = S_RUN;
            end
         end
         S_HALT: begin
            if (go_p) begin
               // The CPU samples resume on this enable.
               cpu_ce     = 1'b1;
               cpu_resume = 1'b1;
               blank_d    = 1'b1;
               state_d    = run_mode ? S_RUN : S_STEP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         blank_q <= blank_d;
      end
   end

   // ---------------------------------------------------------------------
   // Retired-cycle counter (saturating)
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

   always_comb begin
      cycle_count_d = cycle_count_q;
      if (cnt_clr) begin
         cycle_count_d = '0;
      end else if (cpu_ce && (cycle_count_q != {CNT_W{1'b1}})) begin
         cycle_count_d = cycle_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_count_q <= '0;
      end else begin
         cycle_count_q <= cycle_count_d;
      end
   end

   // ---------------------------------------------------------------------
   // Debug address stepper (wraps modulo 2^ADDR_W)
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

   always_comb begin
      mem_addr_d = mem_addr_q;
      if (addr_clr) begin
         mem_addr_d = '0;
      end else begin
         case ({inc_p, dec_p})
            2'b10:   mem_addr_d = mem_addr_q + ADDR_W'(1);
            2'b01:   mem_addr_d = mem_addr_q - ADDR_W'(1);
            default: mem_addr_d = mem_addr_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr_q <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign state       = state_q;
   assign cycle_count = cycle_count_q;

endmodule
